ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameters SHALL be none; the datapath is fixed at 8 bits and the instruction at 19 bits.
REQ-003 Port list, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- ID_EX_A, ID_EX_B  in  8  register operands from the ID/EX register
- ID_EX_instruction  in  19  fields: rd=[13:11], rs=[10:8], rt=[7:5], imm=[7:0]
- alu_op  in  3  ALU operation select
- alu_use_carry, alu_in_mux, select_c, select_z, write_c, write_z  in  1 each  ALU/flag controls
- mem_write, reg_write  in  1 each  controls passed to MEM
- reg_write_mux  in  2  writeback source; 00 selects the ALU result
- MEM_WB_reg_write  in  1  writeback stage will write a register
- MEM_WB_rd  in  3  writeback destination register
- MEM_WB_data  in  8  writeback value
- stall  in  1  hold the stage
- flush  in  1  kill the current instruction
- EX_MEM_result, EX_MEM_store  out  8 each  ALU result and store data
- EX_MEM_rd  out  3  destination register
- EX_MEM_mem_write, EX_MEM_reg_write  out  1 each  registered controls
- EX_MEM_reg_write_mux  out  2  registered writeback source
- carry_flag, zero_flag  out  1 each  architectural C and Z

Function
REQ-004 ALU operations SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 PASS operand B.
- Operand A is the forwarded rs value.
- Operand B is the forwarded rt value when alu_in_mux=0, or zero-extended imm when alu_in_mux=1.
REQ-005 When alu_use_carry=1, ADD SHALL compute A+B+C and SUB SHALL compute A-B-C.
REQ-006 Carry-out SHALL be the 9th sum bit for ADD and the borrow for SUB. For other operations it is 0.
REQ-007 Shift-out SHALL be A[7] for SHL1 and A[0] for SHR1.
REQ-008 When write_c=1, C SHALL load the carry-out (select_c=0) or the shift-out (select_c=1).
REQ-009 When write_z=1, Z SHALL load (result==0) when select_z=0, or Z_old AND (result==0) when select_z=1.
REQ-010 Flags SHALL update at the clock edge closing the instruction's EX cycle, so the next instruction sees them.
REQ-011 The EX/MEM outputs SHALL register result, store data (forwarded rt), rd and the controls with 1-cycle latency.
REQ-012 Forwarding priority SHALL be:
- first, the EX/MEM value, when EX_MEM_reg_write=1, EX_MEM_reg_write_mux=00 and EX_MEM_rd matches;
- then MEM_WB_data, when MEM_WB_reg_write=1 and MEM_WB_rd matches;
- otherwise the ID/EX operand.
REQ-013 Register 0 SHALL never be forwarded.
REQ-014 When stall=1, all EX/MEM outputs and flags SHALL hold their values.
REQ-015 When flush=1, the stage SHALL register a bubble (mem_write=0, reg_write=0, other EX/MEM outputs zero) and SHALL leave the flags unchanged.
REQ-016 If flush and stall are asserted together, flush SHALL win.
REQ-017 All result arithmetic SHALL be modulo 256; flag arithmetic SHALL be 9 bits wide.

Reset
REQ-018 While reset=1 at the clock edge, all EX/MEM outputs, carry_flag and zero_flag SHALL become 0.
REQ-019 Reset SHALL take priority over stall and flush.
REQ-020 An instruction that is in EX when reset is asserted SHALL be discarded with no flag effect.

Configuration
REQ-021 When EX_FORWARDING_EN is defined, forwarding SHALL behave as REQ-012 and REQ-013.
REQ-022 When EX_FORWARDING_EN is undefined, operands SHALL come directly from ID_EX_A and ID_EX_B, and the MEM_WB_* inputs SHALL be ignored.

Verification
REQ-023 ADD A=0xF0, B=0x20, alu_use_carry=0, write_c=1, write_z=1 -> EX_MEM_result=0x10, C=1, Z=0 one cycle later.
REQ-024 Back-to-back: r1 := 0x05; then ADD with rs=r1, ID_EX_A stale 0x00, B=0x01 -> result 0x06 via EX/MEM forwarding. With EX_FORWARDING_EN undefined -> 0x01.
REQ-025 SUB 0x00-0x01 with C=1, alu_use_carry=1, select_c=0 -> result 0xFE, C=1. A following select_z=1 compare with a zero result -> Z=0 (Z_old was 0).
REQ-026 SHR1 A=0x81, select_c=1, write_c=1 with stall=1 for 2 cycles -> outputs and C hold. After release -> result 0x40, C=1.
REQ-027 flush=1 together with stall=1 on a reg_write ADD -> EX_MEM_reg_write=0 and flags unchanged. Then reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_stage_if.sv
// Bundles the ID/EX operands and controls, MEM/WB bypass inputs and the EX/MEM outputs of ex_stage.
interface ex_stage_if;
  logic [7:0]  ID_EX_A;
  logic [7:0]  ID_EX_B;
  logic [18:0] ID_EX_instruction;
  logic [2:0]  alu_op;
  logic        alu_use_carry;
  logic        alu_in_mux;
  logic        select_c;
  logic        select_z;
  logic        write_c;
  logic        write_z;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  reg_write_mux;
  logic        MEM_WB_reg_write;
  logic [2:0]  MEM_WB_rd;
  logic [7:0]  MEM_WB_data;
  logic        stall;
  logic        flush;
  logic [7:0]  EX_MEM_result;
  logic [7:0]  EX_MEM_store;
  logic [2:0]  EX_MEM_rd;
  logic        EX_MEM_mem_write;
  logic        EX_MEM_reg_write;
  logic [1:0]  EX_MEM_reg_write_mux;
  logic        carry_flag;
  logic        zero_flag;

  modport slave (
    input  ID_EX_A, ID_EX_B, ID_EX_instruction, alu_op, alu_use_carry, alu_in_mux,
           select_c, select_z, write_c, write_z, mem_write, reg_write, reg_write_mux,
           MEM_WB_reg_write, MEM_WB_rd, MEM_WB_data, stall, flush,
    output EX_MEM_result, EX_MEM_store, EX_MEM_rd, EX_MEM_mem_write, EX_MEM_reg_write,
           EX_MEM_reg_write_mux, carry_flag, zero_flag
  );

  modport master (
    output ID_EX_A, ID_EX_B, ID_EX_instruction, alu_op, alu_use_carry, alu_in_mux,
           select_c, select_z, write_c, write_z, mem_write, reg_write, reg_write_mux,
           MEM_WB_reg_write, MEM_WB_rd, MEM_WB_data, stall, flush,
    input  EX_MEM_result, EX_MEM_store, EX_MEM_rd, EX_MEM_mem_write, EX_MEM_reg_write,
           EX_MEM_reg_write_mux, carry_flag, zero_flag
  );
endinterface

// File: rtl/ex_stage.sv
// 8-bit execute stage with C/Z flags; EX/MEM registered 1 cycle later, stall holds, flush inserts a bubble.
// Operand bypassing from EX/MEM and MEM/WB is built only when EX_FORWARDING_EN is defined.
module ex_stage (
  input  logic      clk,
  input  logic      reset,
  ex_stage_if.slave io_ex
);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                         OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110;

  logic [7:0] r_result, r_store;
  logic [2:0] r_rd;
  logic       r_mem_write, r_reg_write;
  logic [1:0] r_reg_write_mux;
  logic       r_carry, r_zero;

  logic [2:0] w_rs, w_rt, w_rd;
  logic [7:0] w_imm, w_op_a, w_rt_val, w_op_b, w_result;
  logic [8:0] w_sum;
  logic       w_cin, w_cout, w_shout, w_c_next, w_z_next, w_res_zero;
  logic       w_unused;

  assign w_rd  = io_ex.ID_EX_instruction[13:11];
  assign w_rs  = io_ex.ID_EX_instruction[10:8];
  assign w_rt  = io_ex.ID_EX_instruction[7:5];
  assign w_imm = io_ex.ID_EX_instruction[7:0];

`ifdef EX_FORWARDING_EN
  // Only ALU results (mux 00) exist in EX/MEM yet; r0 is hardwired and never bypassed.
  always_comb begin
    w_op_a   = io_ex.ID_EX_A;
    w_rt_val = io_ex.ID_EX_B;
    if (w_rs != 3'd0 && r_reg_write && r_reg_write_mux == 2'b00 && r_rd == w_rs)
      w_op_a = r_result;
    else if (w_rs != 3'd0 && io_ex.MEM_WB_reg_write && io_ex.MEM_WB_rd == w_rs)
      w_op_a = io_ex.MEM_WB_data;
    if (w_rt != 3'd0 && r_reg_write && r_reg_write_mux == 2'b00 && r_rd == w_rt)
      w_rt_val = r_result;
    else if (w_rt != 3'd0 && io_ex.MEM_WB_reg_write && io_ex.MEM_WB_rd == w_rt)
      w_rt_val = io_ex.MEM_WB_data;
  end
  assign w_unused = ^io_ex.ID_EX_instruction[18:14];
`else
  assign w_op_a   = io_ex.ID_EX_A;
  assign w_rt_val = io_ex.ID_EX_B;
  assign w_unused = ^{io_ex.ID_EX_instruction[18:14], io_ex.MEM_WB_reg_write,
                      io_ex.MEM_WB_rd, io_ex.MEM_WB_data};
`endif

  assign w_op_b = io_ex.alu_in_mux ? w_imm : w_rt_val;
  assign w_cin  = io_ex.alu_use_carry & r_carry;

  always_comb begin
    w_sum    = 9'd0;
    w_result = 8'd0;
    w_cout   = 1'b0;
    w_shout  = 1'b0;
    case (io_ex.alu_op)
      OP_ADD: begin
        w_sum    = {1'b0, w_op_a} + {1'b0, w_op_b} + {8'd0, w_cin};
        w_result = w_sum[7:0];
        w_cout   = w_sum[8];
      end
      // Bit 8 of the 9-bit difference is the borrow.
      OP_SUB: begin
        w_sum    = {1'b0, w_op_a} - {1'b0, w_op_b} - {8'd0, w_cin};
        w_result = w_sum[7:0];
        w_cout   = w_sum[8];
      end
      OP_AND: w_result = w_op_a & w_op_b;
      OP_OR:  w_result = w_op_a | w_op_b;
      OP_XOR: w_result = w_op_a ^ w_op_b;
      OP_SHL: begin
        w_result = {w_op_a[6:0], 1'b0};
        w_shout  = w_op_a[7];
      end
      OP_SHR: begin
        w_result = {1'b0, w_op_a[7:1]};
        w_shout  = w_op_a[0];
      end
      default: w_result = w_op_b;
    endcase
  end

  assign w_res_zero = (w_result == 8'd0);
  assign w_c_next   = io_ex.write_c ? (io_ex.select_c ? w_shout : w_cout) : r_carry;
  assign w_z_next   = io_ex.write_z ? (io_ex.select_z ? (r_zero & w_res_zero) : w_res_zero) : r_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result        <= 8'd0;
      r_store         <= 8'd0;
      r_rd            <= 3'd0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
      r_reg_write_mux <= 2'd0;
      r_carry         <= 1'b0;
      r_zero          <= 1'b0;
    end else if (io_ex.flush) begin
      // Bubble: the killed instruction must not touch the flags.
      r_result        <= 8'd0;
      r_store         <= 8'd0;
      r_rd            <= 3'd0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
      r_reg_write_mux <= 2'd0;
    end else if (!io_ex.stall) begin
      r_result        <= w_result;
      r_store         <= w_rt_val;
      r_rd            <= w_rd;
      r_mem_write     <= io_ex.mem_write;
      r_reg_write     <= io_ex.reg_write;
      r_reg_write_mux <= io_ex.reg_write_mux;
      r_carry         <= w_c_next;
      r_zero          <= w_z_next;
    end
  end

  assign io_ex.EX_MEM_result        = r_result;
  assign io_ex.EX_MEM_store         = r_store;
  assign io_ex.EX_MEM_rd            = r_rd;
  assign io_ex.EX_MEM_mem_write     = r_mem_write;
  assign io_ex.EX_MEM_reg_write     = r_reg_write;
  assign io_ex.EX_MEM_reg_write_mux = r_reg_write_mux;
  assign io_ex.carry_flag           = r_carry;
  assign io_ex.zero_flag            = r_zero;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, hand-written hazard/stall/flush/reset sequences, random run vs model.
module tb_ex_stage;
`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  ex_stage_if bus();

  ex_stage dut (.clk(clk), .reset(reset), .io_ex(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // fl = {use_carry, in_mux, select_c, select_z, write_c, write_z, reg_write}
  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic [2:0] rd, rs;
    logic [7:0] lo8;
    logic [6:0] fl;
    logic [7:0] exp_res;
    logic       exp_c, exp_z;
  } vec_t;

  vec_t tbl [12];

  logic [7:0] m_res, m_store;
  logic [2:0] m_rd;
  logic       m_mw, m_rw, m_c, m_z;
  logic [1:0] m_mux;

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] lo8,
                              input logic [6:0] fl, input logic [7:0] r, input logic c, input logic z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.rs = rs; v.lo8 = lo8; v.fl = fl;
    v.exp_res = r; v.exp_c = c; v.exp_z = z;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.alu_op            = v.op;
    bus.ID_EX_A           = v.a;
    bus.ID_EX_B           = v.b;
    bus.ID_EX_instruction = {5'd0, v.rd, v.rs, v.lo8};
    {bus.alu_use_carry, bus.alu_in_mux, bus.select_c, bus.select_z,
     bus.write_c, bus.write_z, bus.reg_write} = v.fl;
    bus.mem_write     = 1'b0;
    bus.reg_write_mux = 2'b00;
  endtask

  // Value a register read sees, given what EX/MEM and MEM/WB are about to write.
  function automatic int fwd(input logic [2:0] sel, input logic [7:0] idv);
    if (FWD && sel != 3'd0 && m_rw && m_mux == 2'b00 && m_rd == sel) return int'(m_res);
    if (FWD && sel != 3'd0 && bus.MEM_WB_reg_write && bus.MEM_WB_rd == sel) return int'(bus.MEM_WB_data);
    return int'(idv);
  endfunction

  task automatic model_update();
    int a, b, rtv, t, res;
    bit cout, sh, zero, cin;
    if (reset) begin
      m_res = 0; m_store = 0; m_rd = 0; m_mw = 0; m_rw = 0; m_mux = 0; m_c = 0; m_z = 0;
    end else if (bus.flush) begin
      m_res = 0; m_store = 0; m_rd = 0; m_mw = 0; m_rw = 0; m_mux = 0;
    end else if (!bus.stall) begin
      a    = fwd(bus.ID_EX_instruction[10:8], bus.ID_EX_A);
      rtv  = fwd(bus.ID_EX_instruction[7:5], bus.ID_EX_B);
      b    = bus.alu_in_mux ? int'(bus.ID_EX_instruction[7:0]) : rtv;
      cin  = bus.alu_use_carry && m_c;
      cout = 0; sh = 0; res = 0;
      case (bus.alu_op)
        3'd0: begin t = a + b + int'(cin); res = t % 256; cout = (t > 255); end
        3'd1: begin t = a - b - int'(cin); res = (t + 512) % 256; cout = (t < 0); end
        3'd2: res = a & b;
        3'd3: res = a | b;
        3'd4: res = a ^ b;
        3'd5: begin res = (a * 2) % 256; sh = (a >= 128); end
        3'd6: begin res = a / 2; sh = (a % 2 == 1); end
        default: res = b;
      endcase
      zero = (res == 0);
      if (bus.write_c) m_c = bus.select_c ? sh : cout;
      if (bus.write_z) m_z = bus.select_z ? (m_z && zero) : zero;
      m_res = 8'(res); m_store = 8'(rtv); m_rd = bus.ID_EX_instruction[13:11];
      m_mw = bus.mem_write; m_rw = bus.reg_write; m_mux = bus.reg_write_mux;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model", {7'd0, bus.EX_MEM_result, bus.EX_MEM_store, bus.EX_MEM_rd, bus.EX_MEM_mem_write,
                    bus.EX_MEM_reg_write, bus.EX_MEM_reg_write_mux, bus.carry_flag, bus.zero_flag},
                   {7'd0, m_res, m_store, m_rd, m_mw, m_rw, m_mux, m_c, m_z});
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(3'd0, 8'hF0, 8'h20, 3'd1, 3'd0, 8'h00, 7'b0000111, 8'h10, 1'b1, 1'b0);
    tbl[1]  = mk(3'd0, 8'h01, 8'h01, 3'd2, 3'd0, 8'h00, 7'b1000110, 8'h03, 1'b0, 1'b0);
    tbl[2]  = mk(3'd1, 8'h00, 8'h01, 3'd2, 3'd0, 8'h00, 7'b0000110, 8'hFF, 1'b1, 1'b0);
    tbl[3]  = mk(3'd1, 8'h00, 8'h01, 3'd2, 3'd0, 8'h00, 7'b1000110, 8'hFE, 1'b1, 1'b0);
    tbl[4]  = mk(3'd2, 8'h0F, 8'hF0, 3'd2, 3'd0, 8'h00, 7'b0001110, 8'h00, 1'b0, 1'b0);
    tbl[5]  = mk(3'd3, 8'h00, 8'h00, 3'd2, 3'd0, 8'h00, 7'b0000010, 8'h00, 1'b0, 1'b1);
    tbl[6]  = mk(3'd4, 8'hAA, 8'hAA, 3'd2, 3'd0, 8'h00, 7'b0001010, 8'h00, 1'b0, 1'b1);
    tbl[7]  = mk(3'd5, 8'h81, 8'h00, 3'd2, 3'd0, 8'h00, 7'b0010110, 8'h02, 1'b1, 1'b0);
    tbl[8]  = mk(3'd6, 8'h81, 8'h00, 3'd2, 3'd0, 8'h00, 7'b0010100, 8'h40, 1'b1, 1'b0);
    tbl[9]  = mk(3'd7, 8'h00, 8'h55, 3'd2, 3'd0, 8'h1C, 7'b0100110, 8'h1C, 1'b0, 1'b0);
    tbl[10] = mk(3'd0, 8'hFF, 8'h01, 3'd2, 3'd0, 8'h00, 7'b0000110, 8'h00, 1'b1, 1'b1);
    tbl[11] = mk(3'd6, 8'h00, 8'h00, 3'd2, 3'd0, 8'h00, 7'b0011110, 8'h00, 1'b0, 1'b1);

    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.MEM_WB_reg_write = 1'b0; bus.MEM_WB_rd = 3'd0; bus.MEM_WB_data = 8'd0;
    apply(mk(3'd0, 8'hAB, 8'hCD, 3'd5, 3'd0, 8'h00, 7'b0000111, 8'h00, 1'b0, 1'b0));
    step();
    step();
    check("reset_state", {7'd0, bus.EX_MEM_result, bus.EX_MEM_store, bus.EX_MEM_rd, bus.EX_MEM_mem_write,
                          bus.EX_MEM_reg_write, bus.EX_MEM_reg_write_mux, bus.carry_flag, bus.zero_flag}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      step();
      check($sformatf("vec%0d_result", i), {24'd0, bus.EX_MEM_result}, {24'd0, tbl[i].exp_res});
      check($sformatf("vec%0d_cz", i), {30'd0, bus.carry_flag, bus.zero_flag}, {30'd0, tbl[i].exp_c, tbl[i].exp_z});
    end

    // Back-to-back dependency through EX/MEM, then MEM/WB, priority and r0.
    apply(mk(3'd0, 8'h05, 8'h00, 3'd1, 3'd0, 8'h00, 7'b0000001, 8'h00, 1'b0, 1'b0));
    step();
    check("r1_write", {24'd0, bus.EX_MEM_result}, 32'h05);
    apply(mk(3'd0, 8'h00, 8'h01, 3'd2, 3'd1, 8'h00, 7'b0000001, 8'h00, 1'b0, 1'b0));
    step();
    check("fwd_exmem", {24'd0, bus.EX_MEM_result}, FWD ? 32'h06 : 32'h01);
    bus.MEM_WB_reg_write = 1'b1; bus.MEM_WB_rd = 3'd5; bus.MEM_WB_data = 8'h33;
    apply(mk(3'd0, 8'h00, 8'h00, 3'd6, 3'd5, 8'h00, 7'b0000001, 8'h00, 1'b0, 1'b0));
    step();
    check("fwd_memwb", {24'd0, bus.EX_MEM_result}, FWD ? 32'h33 : 32'h00);
    bus.MEM_WB_rd = 3'd6; bus.MEM_WB_data = 8'h77;
    apply(mk(3'd0, 8'h00, 8'h00, 3'd7, 3'd6, 8'h00, 7'b0000001, 8'h00, 1'b0, 1'b0));
    step();
    check("fwd_priority", {24'd0, bus.EX_MEM_result}, FWD ? 32'h33 : 32'h00);
    bus.MEM_WB_reg_write = 1'b0;
    apply(mk(3'd7, 8'h00, 8'h44, 3'd0, 3'd0, 8'h00, 7'b0000001, 8'h00, 1'b0, 1'b0));
    step();
    bus.MEM_WB_reg_write = 1'b1; bus.MEM_WB_rd = 3'd0; bus.MEM_WB_data = 8'h99;
    apply(mk(3'd0, 8'h01, 8'h00, 3'd3, 3'd0, 8'h00, 7'b0000001, 8'h00, 1'b0, 1'b0));
    step();
    check("r0_no_fwd", {24'd0, bus.EX_MEM_result}, 32'h01);
    bus.MEM_WB_reg_write = 1'b0;

    // Stall holds outputs and C, then the held SHR1 completes.
    apply(mk(3'd0, 8'h02, 8'h03, 3'd4, 3'd0, 8'h00, 7'b0000110, 8'h00, 1'b0, 1'b0));
    step();
    v = mk(3'd6, 8'h81, 8'h00, 3'd5, 3'd0, 8'h00, 7'b0010100, 8'h00, 1'b0, 1'b0);
    apply(v);
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("stall%0d_hold", k), {21'd0, bus.EX_MEM_result, bus.EX_MEM_rd, bus.carry_flag},
            {21'd0, 8'h05, 3'd4, 1'b0});
    end
    bus.stall = 1'b0;
    step();
    check("stall_release", {23'd0, bus.EX_MEM_result, bus.carry_flag}, {23'd0, 8'h40, 1'b1});

    // Flush beats stall: bubble out, flags untouched.
    apply(mk(3'd0, 8'hFF, 8'h01, 3'd3, 3'd0, 8'h00, 7'b0000111, 8'h00, 1'b0, 1'b0));
    bus.flush = 1'b1; bus.stall = 1'b1;
    step();
    check("flush_bubble", {19'd0, bus.EX_MEM_result, bus.EX_MEM_rd, bus.EX_MEM_reg_write, bus.carry_flag, bus.zero_flag},
          {19'd0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0});
    bus.flush = 1'b0; bus.stall = 1'b0;
    apply(mk(3'd0, 8'h10, 8'h20, 3'd4, 3'd0, 8'h00, 7'b0000111, 8'h00, 1'b0, 1'b0));
    step();
    check("post_flush_add", {24'd0, bus.EX_MEM_result}, 32'h30);
    apply(mk(3'd0, 8'hFF, 8'h01, 3'd4, 3'd0, 8'h00, 7'b0000111, 8'h00, 1'b0, 1'b0));
    reset = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    check("mid_reset", {7'd0, bus.EX_MEM_result, bus.EX_MEM_store, bus.EX_MEM_rd, bus.EX_MEM_mem_write,
                        bus.EX_MEM_reg_write, bus.EX_MEM_reg_write_mux, bus.carry_flag, bus.zero_flag}, 32'd0);
    reset = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;

    for (int i = 0; i < 600; i++) begin
      bus.ID_EX_A              = 8'($urandom);
      bus.ID_EX_B              = 8'($urandom);
      bus.ID_EX_instruction    = 19'($urandom);
      bus.alu_op               = 3'($urandom);
      {bus.alu_use_carry, bus.alu_in_mux, bus.select_c, bus.select_z, bus.write_c, bus.write_z} = 6'($urandom);
      bus.mem_write            = 1'($urandom);
      bus.reg_write            = ($urandom_range(0, 3) != 0);
      bus.reg_write_mux        = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      bus.MEM_WB_reg_write     = 1'($urandom);
      bus.MEM_WB_rd            = 3'($urandom);
      bus.MEM_WB_data          = 8'($urandom);
      bus.stall                = ($urandom_range(0, 7) == 0);
      bus.flush                = ($urandom_range(0, 9) == 0);
      reset                    = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
